// File: rtl/ah_demux_route_stage_if.sv
// Handshake bundle between the upstream source, the route stage and the demux.
// slave is the route stage's view; master is the view of whoever drives upstream
// beats and the demux-side ready.
interface ah_demux_route_stage_if #(
    parameter int DATA_W = 8,
    parameter int SEL_W  = 6
);
    logic [DATA_W-1:0] up_data;
    logic              up_valid;
    logic              up_ready;
    logic [SEL_W-1:0]  dn_select;
    logic [DATA_W-1:0] dn_data;
    logic              dn_valid;
    logic              dn_ready;

    modport slave (
        input  up_data, up_valid, dn_ready,
        output up_ready, dn_select, dn_data, dn_valid
    );

    modport master (
        output up_data, up_valid, dn_ready,
        input  up_ready, dn_select, dn_data, dn_valid
    );
endinterface

// File: rtl/ah_demux_route_stage.sv
// Ingress route stage in front of the valid/ready demux.
// The header beat of each fixed-length packet selects the egress. The stage
// forwards the packet through one output register and holds the select steady.
// Packets with an out-of-range destination are swallowed.
// Optional build macro AH_ROUTE_DROP_CNT_EN adds a saturating drop counter
// (drop_cnt) with a synchronous clear (drop_cnt_clr).
module ah_demux_route_stage #(
    parameter int DATA_W    = 8,
    parameter int NUM_EGR   = 34,
    parameter int SEL_W     = 6,
    parameter int PKT_BEATS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    ah_demux_route_stage_if.slave bus,
    output logic                  pkt_busy
`ifdef AH_ROUTE_DROP_CNT_EN
    ,
    input  logic                  drop_cnt_clr,
    output logic [15:0]           drop_cnt
`endif
);
    localparam int                 CNT_W    = $clog2(PKT_BEATS + 1);
    localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(PKT_BEATS);
    localparam logic [SEL_W:0]     EGR_LIM  = (SEL_W + 1)'(NUM_EGR);

    typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [SEL_W-1:0] dest;
    logic             in_range;
    logic             accept;
    logic             fwd;
    logic             cnt_last;

    assign dest     = bus.up_data[SEL_W-1:0];
    assign in_range = {1'b0, dest} < EGR_LIM;
    // A dropping packet never touches the output register, so it can drain
    // even while a forwarded beat is still waiting on the demux.
    assign bus.up_ready = (state == DROP) || !bus.dn_valid || bus.dn_ready;
    assign accept   = bus.up_valid && bus.up_ready;
    assign fwd      = accept && ((state == FWD) || ((state == IDLE) && in_range));
    assign cnt_last = (cnt == CNT_W'(1));

    // Output register plus the packet FSM; select is only reloaded by a header.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            pkt_busy      <= 1'b0;
            bus.dn_valid  <= 1'b0;
            bus.dn_data   <= '0;
            bus.dn_select <= '0;
        end else begin
            if (fwd) begin
                bus.dn_valid <= 1'b1;
                bus.dn_data  <= bus.up_data;
                if (state == IDLE) bus.dn_select <= dest;
            end else if (bus.dn_ready) begin
                bus.dn_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt      <= CNT_LOAD;
                        pkt_busy <= 1'b1;
                        state    <= in_range ? FWD : DROP;
                    end
                end
                FWD, DROP: begin
                    if (accept) begin
                        if (cnt_last) begin
                            state    <= IDLE;
                            pkt_busy <= 1'b0;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    pkt_busy <= 1'b0;
                end
            endcase
        end
    end

`ifdef AH_ROUTE_DROP_CNT_EN
    logic drop_hdr;
    assign drop_hdr = accept && (state == IDLE) && !in_range;

    // Saturating count of dropped headers; a clear wins but still counts a
    // coincident drop.
    always_ff @(posedge clk) begin
        if (rst)
            drop_cnt <= '0;
        else if (drop_cnt_clr)
            drop_cnt <= drop_hdr ? 16'd1 : 16'd0;
        else if (drop_hdr && (drop_cnt != 16'hFFFF))
            drop_cnt <= drop_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_ah_demux_route_stage.sv
// Self-checking bench for ah_demux_route_stage: a cycle table for the first
// packet, hand sequences for drop, stall, back-to-back and reset cases, and a
// randomized run. A packet-level scoreboard checks the output stream.
module tb_ah_demux_route_stage;
    logic clk;
    logic rst;
    logic pkt_busy;
    int   errors = 0;
    int   checks = 0;

    ah_demux_route_stage_if #(.DATA_W(8), .SEL_W(6)) bus ();

`ifdef AH_ROUTE_DROP_CNT_EN
    logic        drop_cnt_clr = 1'b0;
    logic [15:0] drop_cnt;
`endif

    ah_demux_route_stage #(.DATA_W(8), .NUM_EGR(34), .SEL_W(6), .PKT_BEATS(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .pkt_busy (pkt_busy)
`ifdef AH_ROUTE_DROP_CNT_EN
        ,
        .drop_cnt_clr (drop_cnt_clr),
        .drop_cnt     (drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // dn_ready driver: 0 = fixed level, 1 = random, 2 = hold low for the
    // first 3 cycles in which an output beat is presented.
    int   rdy_mode  = 0;
    logic rdy_force = 1'b1;
    int   stall_n   = 0;
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            1: bus.dn_ready = ($urandom_range(0, 3) != 0);
            2: begin
                if (bus.dn_valid) stall_n++;
                bus.dn_ready = (stall_n >= 4);
            end
            default: begin
                stall_n = 0;
                bus.dn_ready = rdy_force;
            end
        endcase
    end

    // Packet-level reference: position within the packet, whether it is
    // being dropped, and a queue of beats owed to the demux.
    logic [7:0]  q[$];
    int          pos      = 0;
    logic        dpkt     = 1'b0;
    logic [5:0]  exp_sel  = '0;
    logic [5:0]  m_dest;
    logic        just_rst = 1'b0;
`ifdef AH_ROUTE_DROP_CNT_EN
    logic [15:0] mdl_cnt = '0;
    logic        inc;
`endif

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            pos      = 0;
            dpkt     = 1'b0;
            exp_sel  = '0;
            just_rst = 1'b1;
`ifdef AH_ROUTE_DROP_CNT_EN
            mdl_cnt  = '0;
`endif
        end else begin
            if (just_rst) begin
                chk("rst_dn_valid", 32'(bus.dn_valid), 32'd0);
                chk("rst_dn_data", 32'(bus.dn_data), 32'd0);
                chk("rst_dn_select", 32'(bus.dn_select), 32'd0);
                chk("rst_pkt_busy", 32'(pkt_busy), 32'd0);
                just_rst = 1'b0;
            end
            chk("sb_dn_valid", 32'(bus.dn_valid), 32'(q.size() != 0));
            if (bus.dn_valid && q.size() != 0) chk("sb_dn_data", 32'(bus.dn_data), 32'(q[0]));
            chk("sb_dn_select", 32'(bus.dn_select), 32'(exp_sel));
            chk("sb_pkt_busy", 32'(pkt_busy), 32'(pos != 0));
            chk("sb_up_ready", 32'(bus.up_ready),
                32'((pos != 0 && dpkt) || q.size() == 0 || bus.dn_ready));
`ifdef AH_ROUTE_DROP_CNT_EN
            chk("sb_drop_cnt", 32'(drop_cnt), 32'(mdl_cnt));
            inc = 1'b0;
`endif
            if (bus.dn_valid && bus.dn_ready && q.size() != 0) void'(q.pop_front());
            if (bus.up_valid && bus.up_ready) begin
                if (pos == 0) begin
                    m_dest = bus.up_data[5:0];
                    dpkt   = (m_dest >= 6'd34);
                    if (!dpkt) exp_sel = m_dest;
`ifdef AH_ROUTE_DROP_CNT_EN
                    inc = dpkt;
`endif
                end
                if (!dpkt) q.push_back(bus.up_data);
                pos = (pos == 4) ? 0 : pos + 1;
            end
`ifdef AH_ROUTE_DROP_CNT_EN
            if (drop_cnt_clr) mdl_cnt = inc ? 16'd1 : 16'd0;
            else if (inc && mdl_cnt != 16'hFFFF) mdl_cnt = mdl_cnt + 16'd1;
`endif
        end
    end

    // Present one beat and hold it until accepted (bounded).
    task automatic send(input logic [7:0] d);
        int n;
        n = 0;
        bus.up_data  = d;
        bus.up_valid = 1'b1;
        @(negedge clk);
        while (!bus.up_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no accept expected accept of %0h", d);
        end
        @(posedge clk);
        #1;
        bus.up_valid = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] hdr, input logic [7:0] base);
        send(hdr);
        for (int i = 1; i <= 4; i++) send(base + 8'(i));
    endtask

    typedef struct {
        logic [7:0] din;
        logic       vin;
        logic       dv;
        logic [7:0] dd;
        logic [5:0] ds;
        logic       ur;
        logic       bz;
    } vec_t;
    vec_t tbl[7];

    int vcnt, run, maxrun;

    initial begin
        tbl[0] = '{8'h05, 1'b1, 1'b0, 8'h00, 6'd0, 1'b1, 1'b0};
        tbl[1] = '{8'hA1, 1'b1, 1'b1, 8'h05, 6'd5, 1'b1, 1'b1};
        tbl[2] = '{8'hA2, 1'b1, 1'b1, 8'hA1, 6'd5, 1'b1, 1'b1};
        tbl[3] = '{8'hA3, 1'b1, 1'b1, 8'hA2, 6'd5, 1'b1, 1'b1};
        tbl[4] = '{8'hA4, 1'b1, 1'b1, 8'hA3, 6'd5, 1'b1, 1'b1};
        tbl[5] = '{8'h00, 1'b0, 1'b1, 8'hA4, 6'd5, 1'b1, 1'b0};
        tbl[6] = '{8'h00, 1'b0, 1'b0, 8'h00, 6'd5, 1'b1, 1'b0};

        rst          = 1'b1;
        bus.up_valid = 1'b0;
        bus.up_data  = '0;
        bus.dn_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // 1: single packet to dest 5, cycle by cycle
        for (int i = 0; i < 7; i++) begin
            bus.up_data  = tbl[i].din;
            bus.up_valid = tbl[i].vin;
            @(negedge clk);
            chk("t1_dn_valid", 32'(bus.dn_valid), 32'(tbl[i].dv));
            if (tbl[i].dv) chk("t1_dn_data", 32'(bus.dn_data), 32'(tbl[i].dd));
            chk("t1_dn_select", 32'(bus.dn_select), 32'(tbl[i].ds));
            chk("t1_up_ready", 32'(bus.up_ready), 32'(tbl[i].ur));
            chk("t1_pkt_busy", 32'(pkt_busy), 32'(tbl[i].bz));
            @(posedge clk);
            #1;
        end

        // 2: dropped packet (dest 34) then a dest-33 packet
        send_pkt(8'h22, 8'h10);
        send_pkt(8'h21, 8'h20);
        @(negedge clk);
        chk("t2_dn_select", 32'(bus.dn_select), 32'd33);
`ifdef AH_ROUTE_DROP_CNT_EN
        chk("t2_drop_cnt", 32'(drop_cnt), 32'd1);
`endif
        @(posedge clk);
        #1;

        // 3: dest 3 with the demux stalled for 3 presented cycles
        rdy_mode = 2;
        vcnt = 0;
        fork
            send_pkt(8'h03, 8'h30);
            for (int c = 0; c < 14; c++) begin
                @(negedge clk);
                if (bus.dn_valid && !bus.dn_ready) vcnt++;
            end
        join
        chk("t3_stall_cycles", 32'(vcnt), 32'd3);
        rdy_mode = 0;
        rdy_force = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // 4: back-to-back dest 0 then dest 33, no bubbles
        vcnt = 0; run = 0; maxrun = 0;
        fork
            begin
                send_pkt(8'h00, 8'h40);
                send_pkt(8'h21, 8'h50);
            end
            for (int c = 0; c < 14; c++) begin
                @(negedge clk);
                if (bus.dn_valid) begin
                    vcnt++;
                    run++;
                    if (run > maxrun) maxrun = run;
                    if (bus.dn_data == 8'h21) chk("t4_switch_sel", 32'(bus.dn_select), 32'd33);
                    if (bus.dn_data == 8'h44) chk("t4_first_sel", 32'(bus.dn_select), 32'd0);
                end else begin
                    run = 0;
                end
            end
        join
        chk("t4_valid_count", 32'(vcnt), 32'd10);
        chk("t4_valid_run", 32'(maxrun), 32'd10);

        // 5: reset in the middle of a dest-7 packet
        send(8'h07);
        send(8'hC1);
        send(8'hC2);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("t5_dn_valid", 32'(bus.dn_valid), 32'd0);
        chk("t5_pkt_busy", 32'(pkt_busy), 32'd0);
        chk("t5_dn_select", 32'(bus.dn_select), 32'd0);
        @(posedge clk);
        #1;
        send(8'h02);
        @(negedge clk);
        chk("t5_hdr_valid", 32'(bus.dn_valid), 32'd1);
        chk("t5_hdr_sel", 32'(bus.dn_select), 32'd2);
        @(posedge clk);
        #1;
        for (int i = 1; i <= 4; i++) send(8'hB0 + 8'(i));

        // Randomized packets, gaps and backpressure against the scoreboard
        rdy_mode = 1;
        for (int p = 0; p < 150; p++) begin
            send(8'($urandom_range(0, 255)));
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk);
                    #1;
                end
                send(8'($urandom_range(0, 255)));
            end
        end
        rdy_mode = 0;
        rdy_force = 1'b1;
        repeat (4) @(posedge clk);
        #1;

`ifdef AH_ROUTE_DROP_CNT_EN
        // 6: counter saturation and coincident clear
        for (int p = 0; p < 65537; p++) send_pkt(8'hFF, 8'h00);
        @(negedge clk);
        chk("t6_saturate", 32'(drop_cnt), 32'hFFFF);
        @(posedge clk);
        #1;
        drop_cnt_clr = 1'b1;
        send(8'hFE);
        drop_cnt_clr = 1'b0;
        for (int i = 0; i < 4; i++) send(8'h00);
        @(negedge clk);
        chk("t6_clr_inc", 32'(drop_cnt), 32'd1);
        @(posedge clk);
        #1;
`endif

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ah_demux_route_stage.md
Name: ah_demux_route_stage

Overview:
- Ingress stage that sits directly upstream of the 8-bit, 34-way valid/ready demux.
- Parses the header beat of each fixed-length packet and latches the egress index from it.
- Drives the demux select, data and valid through a registered pipeline stage.
- Holds select constant for the whole packet and drops packets whose destination is out of range.

Parameters:
DATA_W, 8, data width of the up and dn streams
NUM_EGR, 34, number of demux egress ports; legal dest range 0..NUM_EGR-1
SEL_W, 6, select width; requires NUM_EGR <= 2**SEL_W and SEL_W <= DATA_W
PKT_BEATS, 4, payload beats following each header beat (packet = 1 + PKT_BEATS beats); must be >= 1

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset, synchronous, active-high
up_data  in  DATA_W  upstream beat; on a header beat, bits [SEL_W-1:0] = destination index
up_valid  in  1  upstream beat valid
up_ready  out  1  stage can accept a beat
dn_select  out  SEL_W  demux select, registered
dn_data  out  DATA_W  beat to demux ing_data, registered
dn_valid  out  1  beat to demux ing_valid, registered
dn_ready  in  1  demux ing_ready
pkt_busy  out  1  high while a packet (forwarded or dropped) is in progress

Behaviour:
- Reset values: all outputs are 0 after reset. This covers dn_valid, dn_data, dn_select and pkt_busy. FSM = IDLE, beat counter = 0.
- A beat is accepted on a cycle where up_valid & up_ready.
- up_ready = 1 in DROP. Otherwise up_ready = !dn_valid | dn_ready.
  - This is a single pipeline register with full throughput.
  - up_ready is combinational from dn_ready.
- Latency: a forwarded beat accepted in cycle N appears on dn_* in cycle N+1.
- dn_data and dn_select are stable while dn_valid & !dn_ready.
- Output register on dn_valid & dn_ready:
  - If a beat is accepted in the same cycle and it is forwarded, the register loads it and dn_valid stays 1.
  - Otherwise dn_valid is cleared.
- FSM states:
  - IDLE:
    - On an accepted beat, treat it as the header and set dest = up_data[SEL_W-1:0].
    - If dest < NUM_EGR: forward the header beat, set dn_select = dest, load counter = PKT_BEATS, go to FWD.
    - Else: discard the beat, load counter = PKT_BEATS, go to DROP. dn_* are not touched.
  - FWD: each accepted beat is forwarded with dn_select unchanged and decrements the counter. When the counter reaches 1 and a beat is accepted, go to IDLE.
  - DROP: each accepted beat is discarded and decrements the counter. When the counter reaches 1 and a beat is accepted, go to IDLE.
- pkt_busy = (state != IDLE), registered.
- dn_select changes only when a header beat loads the output register. It holds its last value while dn_valid = 0.
- Back-to-back packets: the header of packet k+1 may be accepted in the cycle after the last beat of packet k. No bubble is required.
- A dropped packet may be consumed while the output register still holds an undelivered beat. The held beat is unaffected.
- Reset mid-packet: all state returns to IDLE and any held beat is lost. The next accepted beat is treated as a header.
- Counter width: clog2(PKT_BEATS+1). No wrap: the counter is never decremented below 1 in FWD/DROP.

Optional Feature:
AH_ROUTE_DROP_CNT_EN
- Defined:
  - Adds output port drop_cnt, 16 bits. It increments by 1 on each header beat whose dest >= NUM_EGR.
  - It saturates at 16'hFFFF and resets to 0.
  - Adds input drop_cnt_clr, 1 bit, which clears the counter synchronously.
  - If clear and increment occur in the same cycle, the result is 1.
- Not defined: neither port exists and no counter logic is built. Forwarding behaviour is identical.

Test Plan:
1. Reset, then send packet 0x05,0xA1,0xA2,0xA3,0xA4 with dn_ready=1.
   - dn_select=5 from the cycle after the header.
   - dn_data sequence 0x05,0xA1..0xA4, each beat 1 cycle after its accept.
   - pkt_busy=1 for the 4 payload accept cycles, then 0.
2. Header 0x22 (dest 34, out of range) + 4 beats, followed immediately by header 0x21 + 4 beats.
   - dn_valid=0 throughout the first packet and up_ready=1.
   - The second packet is forwarded with dn_select=33.
   - With AH_ROUTE_DROP_CNT_EN: drop_cnt=1.
3. Forward packet dest 3 with dn_ready held 0 for 3 cycles after the first output.
   - dn_data/dn_select/dn_valid stay frozen and up_ready=0.
   - On release, all 5 beats are delivered in order with no loss or duplication.
4. Back-to-back packets to dest 0 then dest 33 with up_valid and dn_ready continuously 1.
   - 10 consecutive dn_valid beats.
   - dn_select switches 0->33 exactly on the beat carrying header 0x21.
5. Assert rst for 1 cycle after the 2nd payload beat of a dest-7 packet, then send 0x02,0xB1..0xB4.
   - Outputs are 0 in the cycle after reset.
   - 0x02 is treated as a header and forwarded with dn_select=2.
6. With AH_ROUTE_DROP_CNT_EN: send 65536 out-of-range packets, then one more, then pulse drop_cnt_clr coincident with another drop header.
   - drop_cnt saturates at 0xFFFF.
   - drop_cnt becomes 1 after the coincident clear and increment.
